// File: rtl/sort_stream.sv
`default_nettype none
// sort_stream: buffers a frame of up to DEPTH elements, sorts it in place with
// odd-even transposition and streams it back out largest- or smallest-first.

module sort_stream #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 5,
  parameter bit DESCEND = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] SORT_END  = CW'(DEPTH);
  localparam logic [WIDTH-1:0] PAD    = {WIDTH{!DESCEND}};

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] slots  [DEPTH];
  logic [WIDTH-1:0] sorted [DEPTH];
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    sort_cnt;

  logic in_fire;
  logic in_close;
  logic out_fire;

  assign in_fire   = in_valid && in_ready && (state == LOAD);
  assign in_close  = in_fire && (in_last || (cnt == LAST_SLOT));
  assign out_valid = (state == DRAIN);
  assign out_last  = out_valid && (idx == (cnt - CW'(1)));
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state == SORT) || (state == DRAIN);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) == idx) out_data = slots[i];
    end
  end

  // One transposition round; pairs within a phase never overlap, so each
  // compare reads the pre-round slot values.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) sorted[i] = slots[i];
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (i[0] == sort_cnt[0]) begin
        if (DESCEND ? (slots[i] < slots[i+1]) : (slots[i] > slots[i+1])) begin
          sorted[i]   = slots[i+1];
          sorted[i+1] = slots[i];
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (in_close) next_state = SORT;
      SORT:    if (sort_cnt == SORT_END) next_state = DRAIN;
      DRAIN:   if (out_fire && out_last) next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      in_ready <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      sort_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == LOAD);
      case (state)
        LOAD: begin
          sort_cnt <= '0;
          if (in_fire) begin
            cnt <= cnt + CW'(1);
            for (int i = 0; i < DEPTH; i++) begin
              if (CW'(i) == cnt)
                slots[i] <= in_data;
              else if (in_close && (CW'(i) > cnt))
                slots[i] <= PAD;
            end
          end
        end
        SORT: begin
          // DEPTH swap rounds, then one extra cycle before the drain opens.
          sort_cnt <= sort_cnt + CW'(1);
          idx      <= '0;
          if (sort_cnt != SORT_END) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= sorted[i];
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (out_last) begin
              cnt <= '0;
              idx <= '0;
            end else begin
              idx <= idx + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/sort_stream.md
SORT_STREAM -- requirements
Module: sort_stream

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each data element; legal range 1 or more.
REQ-002 Parameter DEPTH, default 5: maximum elements per frame; legal range 2 or more.
REQ-003 Parameter DESCEND, default 1: 1 = output largest first; 0 = output smallest first.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port in_valid, input, 1: in_data/in_last valid this cycle.
REQ-007 Port in_ready, output, 1: block accepts an element this cycle.
REQ-008 Port in_data, input, WIDTH: unsigned element.
REQ-009 Port in_last, input, 1: element is the final one of the frame.
REQ-010 Port out_valid, output, 1: out_data valid.
REQ-011 Port out_ready, input, 1: sink accepts out_data.
REQ-012 Port out_data, output, WIDTH: sorted element.
REQ-013 Port out_last, output, 1: out_data is the final element of the frame.
REQ-014 Port busy, output, 1: high in SORT or DRAIN state.

Function
REQ-015 The FSM SHALL have three states: LOAD, SORT and DRAIN.
REQ-016 A handshake SHALL occur when valid and ready are both high on a rising clk edge.
REQ-017 LOAD: in_ready=1; each input handshake stores in_data at slot cnt and increments cnt (width clog2(DEPTH+1)).
REQ-018 LOAD SHALL go to SORT after the handshake carrying in_last=1, or after the DEPTH-th handshake, whichever comes first.
REQ-019 On leaving LOAD, each slot not loaded SHALL be padded with the value that sorts last: 0 if DESCEND=1, all-ones if DESCEND=0.
REQ-020 SORT: the block SHALL run odd-even transposition for exactly DEPTH cycles: even pairs (0,1),(2,3)... on the 1st, 3rd... cycle; odd pairs (1,2),(3,4)... on the 2nd, 4th... cycle.
REQ-021 Swap rule: a pair SHALL swap only when strictly out of order (lower slot < upper slot for DESCEND=1; lower slot > upper slot for DESCEND=0).
REQ-022 After the DEPTH-th SORT cycle the FSM SHALL go to DRAIN with the read index at 0.
REQ-023 DRAIN: out_valid=1; out_data=slot[idx]; out_last=1 when idx==cnt-1; each output handshake increments idx.
REQ-024 Only cnt elements SHALL be emitted; padding slots SHALL never be emitted.
REQ-025 Handshake on out_last SHALL clear cnt and return the FSM to LOAD; in_ready SHALL be high on the following cycle.
REQ-026 Latency: if the last input handshake is at edge T, out_valid SHALL rise after edge T+DEPTH+1.
REQ-027 While out_ready=0, out_data and out_last SHALL remain stable.
REQ-028 in_ready SHALL be 0 in SORT and DRAIN; input activity in those states SHALL be ignored.
REQ-029 out_valid SHALL be 0 in LOAD and SORT.
REQ-030 A single-element frame (in_last on the first handshake) SHALL still pass through all DEPTH SORT cycles and emit one element with out_last=1.
REQ-031 in_last on the DEPTH-th handshake SHALL behave identically to the DEPTH-th handshake without in_last.

Reset
REQ-032 While rst_n=0: FSM=LOAD, cnt=0, idx=0, in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, and all slots cleared to 0.
REQ-033 in_ready SHALL be registered and go to 1 on the first rising clk edge after rst_n deasserts.
REQ-034 Reset asserted mid-frame in any state SHALL discard the frame immediately, with no partial output afterwards.

Verification
REQ-035 Defaults, input 3,9,1,9,7 (last on 7), out_ready=1 -> outputs 9,9,7,3,1; out_last on 1; out_valid rises 6 cycles after the last input edge.
REQ-036 DESCEND=0, DEPTH=8, WIDTH=8, input 200,5,77 with in_last on 77 -> outputs exactly 5,77,200; out_last on 200; no padding values emitted.
REQ-037 Defaults, 5 elements 0,0,15,0,15 with no in_last -> frame closes after the 5th handshake; outputs 15,15,0,0,0.
REQ-038 During DRAIN, hold out_ready=0 for 4 cycles -> out_data/out_last stable; in_ready=0; in_valid pulses ignored; resuming out_ready gives the correct sequence.
REQ-039 Assert rst_n=0 for one cycle during SORT -> all outputs take reset values; next frame 4,2 (last) -> outputs 4,2 with no residue from the discarded frame.
REQ-040 Two frames back to back with in_valid held high -> second frame accepted starting the cycle after the first frame's out_last handshake; both frames sorted correctly.
